adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline depth and number of carry-chain chunks; WIDTH % STAGES == 0 is required, elaboration error otherwise.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning the operand beat is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the beat is accepted this cycle.
REQ-007 SHALL have ports a and b, inputs, WIDTH each, meaning the operands.
REQ-008 SHALL have port cin, input, 1, meaning carry-in (add) or borrow-in (sub).
REQ-009 SHALL have port sub, input, 1, meaning 1 = subtract, 0 = add.
REQ-010 SHALL have port out_valid, output, 1, meaning the result beat is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream accepts.
REQ-012 SHALL have port sum, output, WIDTH, meaning the result.
REQ-013 SHALL have port cout, output, 1, meaning carry-out (add) or NOT borrow-out (sub).
REQ-014 SHALL have port ovf, output, 1, meaning two's-complement overflow.

Function
REQ-015 Arithmetic: effective operand = sub ? ~b : b; effective carry-in = cin XOR sub; {cout,sum} = a + eff_b + eff_cin, exactly WIDTH+1 bits.
REQ-016 ovf SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-017 Carry chain SHALL be split into STAGES chunks of WIDTH/STAGES bits; stage k resolves chunk k only, using the registered carry from stage k-1.
REQ-018 Unresolved upper operand chunks SHALL be skewed forward with the beat; resolved lower sum chunks SHALL be delayed to align at the output.
REQ-019 Transfer occurs on a cycle where valid && ready is high on the respective side.
REQ-020 advance = !out_valid || out_ready; in_ready SHALL equal advance; when advance is low, every stage register SHALL hold.
REQ-021 Latency: a beat accepted at edge N SHALL present out_valid at edge N+STAGES when no stall occurs; each stall cycle adds exactly one cycle.
REQ-022 Throughput: one beat per cycle while out_ready stays high; bubbles (in_valid low) SHALL propagate as invalid stages without blocking.
REQ-023 Order SHALL be preserved; no beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-024 sum/cout/ovf SHALL stay stable while out_valid && !out_ready.
REQ-025 Simultaneous accept and emit in the same cycle SHALL be legal at full occupancy (STAGES beats in flight).

Reset
REQ-026 While rst_n is low, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0 immediately, independent of clk.
REQ-027 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-028 Beats in flight when reset asserts SHALL be discarded; no stale result SHALL appear after release.

Structure
REQ-029 Package adder_pipe_pkg SHALL hold the chunk-width function (WIDTH/STAGES) and the parameter legality check.
REQ-030 One sub-module, adder_pipe_stage, SHALL implement one chunk adder plus its valid/carry/skew registers, instantiated STAGES times by generate.
REQ-031 The design SHALL contain no combinational path from in_valid to out_valid; out_ready reaches in_ready combinationally only.

Verification (WIDTH=16, STAGES=4)
REQ-032 a=0xFFFF b=0x0001 cin=0 sub=0 -> sum=0x0000 cout=1 ovf=0, out_valid exactly 4 cycles after accept.
REQ-033 a=0x7FFF b=0x0001 add; a=0x0FFF b=0x0001 add -> 0x8000 cout=0 ovf=1; 0x1000 cout=0 ovf=0, with the carry crossing chunks.
REQ-034 sub=1 a=0x0005 b=0x0007 cin=0 -> sum=0xFFFE cout=0 ovf=0; sub=1 a=0x8000 b=0x0001 -> 0x7FFF cout=1 ovf=1.
REQ-035 8 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low for exactly those 3 cycles, outputs held, all 8 results in order.
REQ-036 rst_n pulsed low with 3 beats in flight -> out_valid=0 asynchronously; after release, no output until a new beat arrives, then 4-cycle latency.
REQ-037 Random constrained traffic of 10k beats with random in_valid/out_ready, checked against a WIDTH+1-bit reference model -> zero mismatches.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared helpers for the pipelined adder/subtractor.
//   chunk_w   - bits resolved per pipeline stage (WIDTH / STAGES)
//   params_ok - legality check for a WIDTH/STAGES pair
package adder_pipe_pkg;

    function automatic int unsigned chunk_w(input int unsigned width,
                                            input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic logic params_ok(input int unsigned width,
                                       input int unsigned stages);
        return (width > 0) && (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: one pipeline stage of adder_pipe. Resolves carry-chain
// chunk IDX from the previous stage's registered carry and registers the
// result alongside the skewed operands and the partial sum.
//   clk, rst_n       - clock, asynchronous active-low reset
//   advance          - pipeline enable; all registers hold when low
//   in_valid/carry   - beat valid and carry into chunk IDX
//   in_a, in_b       - operands (b already inverted for subtract)
//   in_sum           - sum with chunks below IDX already resolved
//   out_*            - registered versions after resolving chunk IDX
//   out_ovf          - overflow for this beat, meaningful from the last stage
module adder_pipe_stage
    import adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4,
    parameter int unsigned IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             in_valid,
    input  logic             in_carry,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    output logic             out_valid,
    output logic             out_carry,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned CW = chunk_w(WIDTH, STAGES);
    localparam int unsigned LO = IDX * CW;

    logic [CW-1:0]    a_c;
    logic [CW-1:0]    b_c;
    logic [CW-1:0]    s_c;
    logic             c_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             ovf_nxt;

    always_comb begin
        a_c            = in_a[LO +: CW];
        b_c            = in_b[LO +: CW];
        {c_nxt, s_c}   = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, in_carry};
        sum_nxt        = in_sum;
        sum_nxt[LO +: CW] = s_c;
        // a^b^s at the chunk MSB recovers the carry into that bit.
        ovf_nxt        = a_c[CW-1] ^ b_c[CW-1] ^ s_c[CW-1] ^ c_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_carry <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_carry <= c_nxt;
            out_a     <= in_a;
            out_b     <= in_b;
            out_sum   <= sum_nxt;
            out_ovf   <= ovf_nxt;
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: valid/ready pipelined adder/subtractor with the carry chain
// split into STAGES chunks, one chunk resolved per stage.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid, in_ready   - input handshake
//   a, b, cin, sub       - operands, carry/borrow-in, subtract select
//   out_valid, out_ready - output handshake
//   sum, cout, ovf       - result, carry-out (NOT borrow on sub), overflow
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("adder_pipe: WIDTH must be a nonzero multiple of STAGES");
    end

    logic             advance;
    logic             v_in_q;
    logic             c_in_q;
    logic [WIDTH-1:0] a_in_q;
    logic [WIDTH-1:0] b_in_q;

    // Index 0 is the operand capture register, index k+1 is stage k output.
    logic             v_pipe   [0:STAGES];
    logic             c_pipe   [0:STAGES];
    logic [WIDTH-1:0] a_pipe   [0:STAGES];
    logic [WIDTH-1:0] b_pipe   [0:STAGES];
    logic [WIDTH-1:0] s_pipe   [0:STAGES];
    logic             ovf_pipe [0:STAGES-1];

    assign advance = !out_valid || out_ready;
    assign in_ready = advance;

    // Operands are captured before the first chunk so every stage works from
    // registered inputs; results land STAGES edges after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_in_q <= 1'b0;
            c_in_q <= 1'b0;
            a_in_q <= '0;
            b_in_q <= '0;
        end else if (advance) begin
            v_in_q <= in_valid;
            c_in_q <= cin ^ sub;
            a_in_q <= a;
            b_in_q <= sub ? ~b : b;
        end
    end

    assign v_pipe[0] = v_in_q;
    assign c_pipe[0] = c_in_q;
    assign a_pipe[0] = a_in_q;
    assign b_pipe[0] = b_in_q;
    assign s_pipe[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_valid  (v_pipe[k]),
            .in_carry  (c_pipe[k]),
            .in_a      (a_pipe[k]),
            .in_b      (b_pipe[k]),
            .in_sum    (s_pipe[k]),
            .out_valid (v_pipe[k+1]),
            .out_carry (c_pipe[k+1]),
            .out_a     (a_pipe[k+1]),
            .out_b     (b_pipe[k+1]),
            .out_sum   (s_pipe[k+1]),
            .out_ovf   (ovf_pipe[k])
        );
    end

    assign out_valid = v_pipe[STAGES];
    assign sum       = s_pipe[STAGES];
    assign cout      = c_pipe[STAGES];
    assign ovf       = ovf_pipe[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q[$];          // {ovf, cout, sum}
    logic        held_pending = 1'b0;
    logic [17:0] held_val;
    int          tick_no = 0;
    logic        last_ov;
    logic        last_ir;

    // Directed batch: operands and hand-computed {ovf, cout, sum}.
    logic [15:0] da  [7] = '{16'h7FFF, 16'h0FFF, 16'h0005, 16'h8000, 16'h1234, 16'h0010, 16'hFFFF};
    logic [15:0] db  [7] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'h0001, 16'hFFFF};
    logic        dc  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        ds  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [17:0] dexp[7] = '{{1'b1, 1'b0, 16'h8000},
                             {1'b0, 1'b0, 16'h1000},
                             {1'b0, 1'b0, 16'hFFFE},
                             {1'b1, 1'b1, 16'h7FFF},
                             {1'b0, 1'b0, 16'h5556},
                             {1'b0, 1'b1, 16'h000E},
                             {1'b0, 1'b1, 16'hFFFF}};

    always #5 clk = ~clk;

    adder_pipe #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: WIDTH+1-bit sum; overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] eb;
        logic [16:0] r;
        logic        o;
        eb = ms ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, eb} + {16'd0, mc ^ ms};
        o  = (ma[15] == eb[15]) && (r[15] != ma[15]);
        return {o, r[16], r[15:0]};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // One cycle: drive at the falling edge, sample 1ns later, then wait for the
    // next falling edge. acc reports whether the beat is taken at the rising edge.
    task automatic tick(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic is, input logic orr, output logic acc);
        logic [17:0] obs;
        logic [17:0] e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = orr;
        #1;
        obs     = {ovf, cout, sum};
        last_ov = out_valid;
        last_ir = in_ready;
        if (held_pending) check("hold", obs, held_val);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("result", obs, e);
            end
        end
        held_pending = out_valid && !out_ready;
        held_val     = obs;
        acc          = in_valid && in_ready;
        tick_no++;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        int          t_acc;
        int          seen;
        int          idx;
        int          cnt;
        logic [15:0] ra, rb;
        logic        rc, rs, riv;

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_result", {ovf, cout, sum}, 18'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 0xFFFF + 1: wrap with carry-out and 4-cycle latency
        t_acc = tick_no;
        tick(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        check("accept_first", acc, 1'b1);
        exp_q.push_back({1'b0, 1'b1, 16'h0000});
        seen = -100;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            if (last_ov) seen = tick_no - 1;
        end
        check("latency", seen - (t_acc + 1), 4);
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        check("bubble_after", last_ov, 1'b0);

        // Directed add/sub batch, back to back
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, da[i], db[i], dc[i], ds[i], 1'b1, acc);
            check("accept_dir", acc, 1'b1);
            exp_q.push_back(dexp[i]);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        check("dir_drain", exp_q.size(), 0);

        // 8 beats with out_ready low for 3 cycles mid-stream
        idx = 0;
        cnt = 0;
        for (int t = 0; t < 40 && (idx < 8 || exp_q.size() != 0); t++) begin
            ra = 16'(idx * 16'h2345 + 16'h7000);
            rb = 16'(16'hC0DE ^ (idx * 16'h0101));
            rs = idx[0];
            rc = idx[1];
            tick(idx < 8, ra, rb, rc, rs, !(t >= 6 && t <= 8), acc);
            if (!last_ir) cnt++;
            if (acc) begin
                exp_q.push_back(model(ra, rb, rc, rs));
                idx++;
            end
        end
        check("stall_inready_low", cnt, 3);
        check("stall_beats", idx, 8);
        check("stall_drain", exp_q.size(), 0);

        // Reset with 3 beats in flight and the output stalled
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 16'h1111 * 16'(i + 1), 16'h0F0F, 1'b0, 1'b0, 1'b0, acc);
            exp_q.push_back(model(16'h1111 * 16'(i + 1), 16'h0F0F, 1'b0, 1'b0));
        end
        for (int i = 0; i < 4; i++)
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        check("pre_reset_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_result", {ovf, cout, sum}, 18'h0);
        check("async_rst_inready", in_ready, 1'b1);
        exp_q.delete();
        held_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            if (last_ov) cnt++;
        end
        check("no_stale", cnt, 0);
        t_acc = tick_no;
        tick(1'b1, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        exp_q.push_back({1'b0, 1'b0, 16'h1000});
        seen = -100;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            if (last_ov) seen = tick_no - 1;
        end
        check("latency_after_rst", seen - (t_acc + 1), 4);
        check("post_rst_drain", exp_q.size(), 0);

        // Random traffic against the reference model
        idx = 0;
        for (int t = 0; t < 60000 && (idx < 10000 || exp_q.size() != 0); t++) begin
            ra  = pick();
            rb  = pick();
            rc  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            riv = (idx < 10000) && ($urandom_range(0, 9) < 7);
            tick(riv, ra, rb, rc, rs, $urandom_range(0, 9) < 7, acc);
            if (acc) begin
                exp_q.push_back(model(ra, rb, rc, rs));
                idx++;
            end
        end
        check("random_beats", idx, 10000);
        check("random_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
